reg_spill_fill: RTL and testbench
=================================

Name: reg_spill_fill

Overview:
- Block-transfer engine that drives the other side of the register file's port pair: its read-address/read-data port and its write port.
- Spill mode: reads a contiguous run of registers and writes them to data memory.
- Fill mode: reads data memory and writes the run back into the register file.
- Sits beside the core datapath. It is used for context save/restore and for multi-register store/load, and it arbitrates with the core through a per-cycle grant.

Parameters:
- PW, 4, register pointer width; 2**PW registers; register address ports are PW+1 bits wide, matching the register file.
- AW, 8, data-memory address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = spill (reg->mem), 1 = fill (mem->reg); latched on accepted start.
- first_reg  input  PW+1  first register index; latched on start.
- count  input  PW+1  number of registers, 1..2**PW; latched on start.
- base_addr  input  AW  first memory address; latched on start.
- grant  input  1  core yields the reg-file/memory ports this cycle.
- rf_rd_addr  output  PW+1  register-file read address.
- rf_rd_dat  input  8  register-file combinational read data.
- rf_wr_en  output  1  register-file write enable.
- rf_wr_addr  output  PW+1  register-file write address.
- rf_wr_dat  output  8  register-file write data.
- mem_addr  output  AW  data-memory address (combinational read, clocked write).
- mem_wr_en  output  1  data-memory write enable.
- mem_wr_dat  output  8  data-memory write data.
- mem_rd_dat  input  8  data-memory combinational read data.
- busy  output  1  high in XFER.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- States: IDLE, XFER, DONE, ERR.
- Reset (async) forces IDLE, index counter idx=0, latched parameters=0.
- Reset values: busy=0, done=0, err=0, rf_wr_en=0, mem_wr_en=0, all address/data outputs 0.
- IDLE + start=1: latch mode, first_reg, count, base_addr; idx<=0.
  - Invalid request (count==0, or first_reg+count > 2**PW, computed at PW+2 bits): go to ERR.
  - Otherwise: go to XFER.
- start while not in IDLE is ignored; it is not queued.
- XFER, element idx:
  - Register address = first_reg+idx.
  - Memory address = (base_addr+idx) mod 2**AW; wraps from 255 to 0 with no error.
  - Spill: rf_rd_addr = register address; mem_wr_dat = rf_rd_dat; mem_wr_en = grant.
  - Fill: rf_wr_addr = register address; rf_wr_dat = mem_rd_dat; rf_wr_en = grant.
  - Write enables are combinational in grant and the state; they are never asserted outside XFER.
  - grant=1: element is committed at the clock edge, idx<=idx+1. If idx==count-1, go to DONE.
  - grant=0: idx holds, no write, addresses stay stable.
- Latency: count granted cycles in XFER, then one DONE cycle. With grant held high, done is asserted count+1 cycles after the start edge.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start in DONE is ignored.
- ERR: err=1 for exactly one cycle, no reg/mem write issued, then IDLE.
- Outside XFER: address/data outputs drive 0.
- Reset mid-transfer: write enables drop immediately (async). Elements already committed stay written. No done pulse.
- Fill with overlapping spill source is not detected; the transfer order is ascending idx.

Test Plan:
- Spill, first_reg=2, count=3, base=0x10, grant=1, regs 2..4 = 0xA1,0xB2,0xC3 -> mem[0x10..0x12] = 0xA1,0xB2,0xC3; done pulses on cycle 4 after start; busy high cycles 1-3.
- Fill, first_reg=0, count=16, base=0xF8, mem[0xF8..0xFF,0x00..0x07] = n+1 -> r0..r15 = 1..16; mem address wraps 0xFF->0x00.
- Spill count=4 with grant=0 on cycles 2 and 3 -> exactly 4 mem writes, no duplicated or skipped addresses; done 7 cycles after start.
- first_reg=14, count=3 -> err pulses one cycle; no rf_wr_en/mem_wr_en ever high; back in IDLE. count=0 gives the same result.
- Assert reset during element 2 of a 5-register fill -> outputs 0 immediately; only elements 0-1 written; no done; a new start after reset completes normally.
- start pulsed while busy -> ignored; the original transfer completes unchanged with a single done.

Source files
------------

// File: rtl/reg_spill_fill.sv
// Block-transfer engine between the register file and data memory.
// Spill copies a register run to memory, fill copies memory back; each element waits for grant_i.
module reg_spill_fill #(
  parameter int unsigned PW = 4,
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [PW:0]   first_reg_i,
  input  logic [PW:0]   count_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic          grant_i,
  output logic [PW:0]   rf_rd_addr_o,
  input  logic [7:0]    rf_rd_dat_i,
  output logic          rf_wr_en_o,
  output logic [PW:0]   rf_wr_addr_o,
  output logic [7:0]    rf_wr_dat_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_wr_en_o,
  output logic [7:0]    mem_wr_dat_o,
  input  logic [7:0]    mem_rd_dat_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone, StErr} state_e;

  localparam logic [PW+1:0] NumRegs = {2'b01, {PW{1'b0}}};

  state_e        state_q;
  logic [PW:0]   idx_q;
  logic          mode_q;
  logic [PW:0]   first_q;
  logic [PW:0]   count_q;
  logic [AW-1:0] base_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [PW+1:0] req_end;
  logic          req_bad;
  logic          last_elem;
  logic [PW:0]   reg_addr;
  logic [AW-1:0] elem_addr;

  // Range check is one bit wider than the pointer so first+count cannot wrap.
  assign req_end   = {1'b0, first_reg_i} + {1'b0, count_i};
  assign req_bad   = (count_i == '0) || (req_end > NumRegs);
  assign last_elem = (idx_q == count_q - (PW+1)'(1));
  assign reg_addr  = first_q + idx_q;
  assign elem_addr = base_q + AW'(idx_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      first_q <= '0;
      count_q <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            mode_q  <= mode_i;
            first_q <= first_reg_i;
            count_q <= count_i;
            base_q  <= base_addr_i;
            idx_q   <= '0;
            if (req_bad) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              state_q <= StXfer;
              busy_q  <= 1'b1;
            end
          end
        end
        StXfer: begin
          if (grant_i) begin
            if (last_elem) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + (PW+1)'(1);
            end
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Port drive is combinational in state so an async reset drops the write enables at once.
  always_comb begin
    rf_rd_addr_o = '0;
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = '0;
    rf_wr_dat_o  = '0;
    mem_addr_o   = '0;
    mem_wr_en_o  = 1'b0;
    mem_wr_dat_o = '0;
    if (state_q == StXfer) begin
      mem_addr_o = elem_addr;
      if (mode_q) begin
        rf_wr_addr_o = reg_addr;
        rf_wr_dat_o  = mem_rd_dat_i;
        rf_wr_en_o   = grant_i;
      end else begin
        rf_rd_addr_o = reg_addr;
        mem_wr_dat_o = rf_rd_dat_i;
        mem_wr_en_o  = grant_i;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_reg_spill_fill.sv
// Directed bench for reg_spill_fill with behavioural register file and data memory.
module tb_reg_spill_fill;
  localparam int PW = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, mode, grant;
  logic [PW:0]   first_reg, count;
  logic [AW-1:0] base_addr;
  logic [PW:0]   rf_rd_addr, rf_wr_addr;
  logic [7:0]    rf_rd_dat, rf_wr_dat, mem_wr_dat, mem_rd_dat;
  logic          rf_wr_en, mem_wr_en, busy, done, err;
  logic [AW-1:0] mem_addr;

  logic [7:0]    rf  [0:31];
  logic [7:0]    mem [0:255];
  int            mem_wr_cnt = 0;
  int            rf_wr_cnt  = 0;
  int            done_cnt   = 0;
  logic [AW-1:0] mem_log[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_spill_fill #(.PW(PW), .AW(AW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .first_reg_i(first_reg), .count_i(count), .base_addr_i(base_addr), .grant_i(grant),
    .rf_rd_addr_o(rf_rd_addr), .rf_rd_dat_i(rf_rd_dat), .rf_wr_en_o(rf_wr_en),
    .rf_wr_addr_o(rf_wr_addr), .rf_wr_dat_o(rf_wr_dat), .mem_addr_o(mem_addr),
    .mem_wr_en_o(mem_wr_en), .mem_wr_dat_o(mem_wr_dat), .mem_rd_dat_i(mem_rd_dat),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  assign rf_rd_dat  = rf[rf_rd_addr];
  assign mem_rd_dat = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_dat;
      mem_wr_cnt    <= mem_wr_cnt + 1;
      mem_log.push_back(mem_addr);
    end
    if (rf_wr_en) begin
      rf[rf_wr_addr] <= rf_wr_dat;
      rf_wr_cnt      <= rf_wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic m, input int f, input int c, input int b);
    @(negedge clk);
    mode      = m;
    first_reg = (PW+1)'(f);
    count     = (PW+1)'(c);
    base_addr = AW'(b);
    grant     = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs cycles 1..limit after the start edge; bit k of the masks drives grant/start in cycle k.
  task automatic run(input int limit, input logic [31:0] gmask, input logic [31:0] smask,
                     output int dcyc, output int ecyc, output int bcyc,
                     output int dn, output int en);
    dcyc = 0; ecyc = 0; bcyc = 0; dn = 0; en = 0;
    for (int k = 1; k <= limit; k++) begin
      grant = gmask[k];
      start = smask[k];
      #1;
      if (busy) bcyc++;
      if (done) begin dn++; if (dcyc == 0) dcyc = k; end
      if (err)  begin en++; if (ecyc == 0) ecyc = k; end
      if (k < limit) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int dcyc, ecyc, bcyc, dn, en;
    int m0, r0, d0, l0;
    logic [7:0] a;

    reset = 1'b1; start = 1'b0; mode = 1'b0; grant = 1'b0;
    first_reg = '0; count = '0; base_addr = '0;
    for (int i = 0; i < 32; i++) rf[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wren", 32'({rf_wr_en, mem_wr_en}), 0);
    chk("rst_addr", 32'({rf_rd_addr, rf_wr_addr, mem_addr}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Spill r2..r4 to 0x10..0x12
    rf[2] = 8'hA1; rf[3] = 8'hB2; rf[4] = 8'hC3;
    m0 = mem_wr_cnt; r0 = rf_wr_cnt;
    do_start(1'b0, 2, 3, 8'h10);
    #1;
    chk("sp_rdaddr", 32'(rf_rd_addr), 2);
    chk("sp_maddr", 32'(mem_addr), 32'h10);
    chk("sp_wdat", 32'(mem_wr_dat), 32'hA1);
    chk("sp_wen", 32'(mem_wr_en), 1);
    run(6, 32'hFFFF_FFFF, 0, dcyc, ecyc, bcyc, dn, en);
    chk("sp_done_cyc", 32'(dcyc), 4);
    chk("sp_busy_cyc", 32'(bcyc), 3);
    chk("sp_done_n", 32'(dn), 1);
    chk("sp_mem10", 32'(mem[8'h10]), 32'hA1);
    chk("sp_mem11", 32'(mem[8'h11]), 32'hB2);
    chk("sp_mem12", 32'(mem[8'h12]), 32'hC3);
    chk("sp_nwr", 32'(mem_wr_cnt - m0), 3);
    chk("sp_nrf", 32'(rf_wr_cnt - r0), 0);

    // Fill r0..r15 from 0xF8.. with memory address wrap
    for (int n = 0; n < 16; n++) begin
      a = 8'hF8 + 8'(n);
      mem[a] = 8'(n + 1);
      rf[n] = 8'h00;
    end
    m0 = mem_wr_cnt; r0 = rf_wr_cnt;
    do_start(1'b1, 0, 16, 8'hF8);
    run(19, 32'hFFFF_FFFF, 0, dcyc, ecyc, bcyc, dn, en);
    chk("fl_done_cyc", 32'(dcyc), 17);
    chk("fl_busy_cyc", 32'(bcyc), 16);
    chk("fl_nrf", 32'(rf_wr_cnt - r0), 16);
    chk("fl_nmem", 32'(mem_wr_cnt - m0), 0);
    for (int n = 0; n < 16; n++) chk($sformatf("fl_r%0d", n), 32'(rf[n]), 32'(n + 1));

    // Spill of 4 with grant low in cycles 2 and 3
    rf[8] = 8'h11; rf[9] = 8'h22; rf[10] = 8'h33; rf[11] = 8'h44;
    m0 = mem_wr_cnt; l0 = mem_log.size();
    do_start(1'b0, 8, 4, 8'h30);
    run(9, 32'hFFFF_FFF3, 0, dcyc, ecyc, bcyc, dn, en);
    chk("gs_done_cyc", 32'(dcyc), 7);
    chk("gs_busy_cyc", 32'(bcyc), 6);
    chk("gs_nwr", 32'(mem_wr_cnt - m0), 4);
    for (int i = 0; i < 4; i++) begin
      if (mem_log.size() > l0 + i) chk($sformatf("gs_log%0d", i), 32'(mem_log[l0 + i]), 32'h30 + i);
      else chk($sformatf("gs_log%0d", i), 32'hDEAD, 32'h30 + i);
    end
    chk("gs_mem33", 32'(mem[8'h33]), 32'h44);

    // Rejected requests: range overflow, then zero count
    m0 = mem_wr_cnt; r0 = rf_wr_cnt;
    do_start(1'b0, 14, 3, 8'h00);
    run(3, 32'hFFFF_FFFF, 0, dcyc, ecyc, bcyc, dn, en);
    chk("er1_err_cyc", 32'(ecyc), 1);
    chk("er1_err_n", 32'(en), 1);
    chk("er1_done_n", 32'(dn), 0);
    chk("er1_busy", 32'(bcyc), 0);
    do_start(1'b1, 2, 0, 8'h50);
    run(3, 32'hFFFF_FFFF, 0, dcyc, ecyc, bcyc, dn, en);
    chk("er0_err_cyc", 32'(ecyc), 1);
    chk("er0_err_n", 32'(en), 1);
    chk("er0_done_n", 32'(dn), 0);
    chk("er_nwr", 32'((mem_wr_cnt - m0) + (rf_wr_cnt - r0)), 0);

    // Reset during element 2 of a 5-register fill
    for (int i = 0; i < 5; i++) begin
      a = 8'h40 + 8'(i);
      mem[a] = 8'h51 + 8'(i);
      rf[4 + i] = 8'h00;
    end
    r0 = rf_wr_cnt; d0 = done_cnt;
    do_start(1'b1, 4, 5, 8'h40);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rs_pre_addr", 32'(rf_wr_addr), 6);
    reset = 1'b1;
    #1;
    chk("rs_wren", 32'({rf_wr_en, mem_wr_en}), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_addr", 32'({rf_wr_addr, mem_addr}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_nrf", 32'(rf_wr_cnt - r0), 2);
    chk("rs_r4", 32'(rf[4]), 32'h51);
    chk("rs_r5", 32'(rf[5]), 32'h52);
    chk("rs_r6", 32'(rf[6]), 0);
    chk("rs_ndone", 32'(done_cnt - d0), 0);
    do_start(1'b1, 4, 5, 8'h40);
    run(8, 32'hFFFF_FFFF, 0, dcyc, ecyc, bcyc, dn, en);
    chk("rs2_done_cyc", 32'(dcyc), 6);
    chk("rs2_r6", 32'(rf[6]), 32'h53);
    chk("rs2_r8", 32'(rf[8]), 32'h55);

    // start pulses while busy and in DONE are ignored
    rf[0] = 8'h5A; rf[1] = 8'hA5;
    m0 = mem_wr_cnt; r0 = rf_wr_cnt; l0 = mem_log.size();
    do_start(1'b0, 0, 2, 8'h80);
    mode = 1'b1; first_reg = 5'd5; count = 5'd1; base_addr = 8'h90;
    run(6, 32'hFFFF_FFFF, 32'h0000_000E, dcyc, ecyc, bcyc, dn, en);
    chk("sb_done_cyc", 32'(dcyc), 3);
    chk("sb_done_n", 32'(dn), 1);
    chk("sb_err_n", 32'(en), 0);
    chk("sb_busy_cyc", 32'(bcyc), 2);
    chk("sb_nwr", 32'(mem_wr_cnt - m0), 2);
    chk("sb_nrf", 32'(rf_wr_cnt - r0), 0);
    chk("sb_mem80", 32'(mem[8'h80]), 32'h5A);
    chk("sb_mem81", 32'(mem[8'h81]), 32'hA5);
    if (mem_log.size() > l0) chk("sb_log0", 32'(mem_log[l0]), 32'h80);
    else chk("sb_log0", 32'hDEAD, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
